iq_sym_averager: RTL

- Parametrised successor to the single-channel IQ PUF front end.
- Coherently averages 2^k consecutive received symbols of SYM_LEN complex samples, for example repeated LTF symbols, to suppress noise before key or feature extraction.
- Sits between the radio RX AXI-stream and the PUF/key-extraction stage.
- Store-and-forward: accumulates, then drains one averaged symbol framed with tlast.

---
 rtl/iq_sym_avg_pkg.sv | 40 ++++
 rtl/iq_acc_ram.sv | 33 +++
 rtl/iq_sym_averager.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/iq_sym_avg_pkg.sv
// Shared types, default sizes and the round/saturate helper for the IQ symbol averager.
package iq_sym_avg_pkg;

    localparam int DATA_WIDTH_DEF   = 16;
    localparam int SYM_LEN_DEF      = 64;
    localparam int MAX_AVG_LOG2_DEF = 3;

    localparam int ACC_W = DATA_WIDTH_DEF + MAX_AVG_LOG2_DEF;
    localparam int IDX_W = $clog2(SYM_LEN_DEF);
    localparam int SYM_W = MAX_AVG_LOG2_DEF + 1;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } avgState_t;

    // Divide by 2^k rounding half up, then clamp into a dw-bit signed range.
    function automatic logic signed [63:0] roundSat(input logic signed [63:0] acc,
                                                    input int                 k,
                                                    input int                 dw);
        logic signed [63:0] sum;
        logic signed [63:0] res;
        logic signed [63:0] maxV;
        logic signed [63:0] minV;
        sum = acc;
        if (k > 0) begin
            sum = acc + (64'sd1 <<< (k - 1));
        end
        res  = sum >>> k;
        maxV = (64'sd1 <<< (dw - 1)) - 64'sd1;
        minV = -(64'sd1 <<< (dw - 1));
        if (res > maxV) begin
            res = maxV;
        end else if (res < minV) begin
            res = minV;
        end
        return res;
    endfunction

endpackage

// File: rtl/iq_acc_ram.sv
// Accumulator storage: one write port and one synchronous read port with same-address write forwarding.
module iq_acc_ram
    import iq_sym_avg_pkg::*;
#(
    parameter int DEPTH  = SYM_LEN_DEF,
    parameter int WIDTH  = 2 * ACC_W,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wrEn,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic [WIDTH-1:0]  i_wrData,
    input  logic [ADDR_W-1:0] i_rdAddr,
    output logic [WIDTH-1:0]  o_rdData
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdData;

    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
        if (i_wrEn && (i_wrAddr == i_rdAddr)) begin
            r_rdData <= i_wrData;
        end else begin
            r_rdData <= r_mem[i_rdAddr];
        end
    end

    assign o_rdData = r_rdData;

endmodule

// File: rtl/iq_sym_averager.sv
// Coherent IQ averager: sums 2^k received symbols, then streams one rounded, saturated symbol framed by tlast.
module iq_sym_averager
    import iq_sym_avg_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int SYM_LEN      = SYM_LEN_DEF,
    parameter int MAX_AVG_LOG2 = MAX_AVG_LOG2_DEF
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [$clog2(MAX_AVG_LOG2+1)-1:0] avg_log2,
    input  logic [2*DATA_WIDTH-1:0]           in_tdata,
    input  logic                              in_tvalid,
    input  logic                              in_tlast,
    output logic                              in_tready,
    output logic [2*DATA_WIDTH-1:0]           out_tdata,
    output logic                              out_tvalid,
    output logic                              out_tlast,
    input  logic                              out_tready,
    output logic                              sym_done,
    output logic [15:0]                       abort_count
);

    localparam int AW = DATA_WIDTH + MAX_AVG_LOG2;
    localparam int IW = $clog2(SYM_LEN);
    localparam int SW = MAX_AVG_LOG2 + 1;
    localparam int KW = $clog2(MAX_AVG_LOG2 + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(SYM_LEN - 1);

    avgState_t               r_state;
    logic [IW-1:0]           r_idx;
    logic [SW-1:0]           r_sym;
    logic [KW-1:0]           r_kLat;
    logic                    r_inReady;
    logic                    r_rdValid;
    logic                    r_outValid;
    logic                    r_outLast;
    logic                    r_symDone;
    logic [2*DATA_WIDTH-1:0] r_outData;
    logic [15:0]             r_abortCnt;

    logic [KW-1:0]           w_kClip;
    logic [SW-1:0]           w_symTarget;
    logic                    w_inAccept;
    logic                    w_finalSample;
    logic                    w_abort;
    logic                    w_wrEn;
    logic                    w_loadOut;
    logic                    w_lastHs;
    logic [IW-1:0]           w_rdAddr;
    logic [2*AW-1:0]         w_rdData;
    logic [2*AW-1:0]         w_wrData;
    logic signed [AW-1:0]    w_smpI;
    logic signed [AW-1:0]    w_smpQ;
    logic signed [AW-1:0]    w_accI;
    logic signed [AW-1:0]    w_accQ;
    logic [DATA_WIDTH-1:0]   w_outI;
    logic [DATA_WIDTH-1:0]   w_outQ;

    assign w_kClip       = (avg_log2 > KW'(MAX_AVG_LOG2)) ? KW'(MAX_AVG_LOG2) : avg_log2;
    assign w_symTarget   = (SW'(1) << r_kLat) - SW'(1);
    assign w_inAccept    = (r_state == ACCUM) && r_inReady && in_tvalid;
    assign w_finalSample = (r_idx == LAST_IDX) && (r_sym == w_symTarget);
    assign w_abort       = w_inAccept && in_tlast && !w_finalSample;
    assign w_wrEn        = w_inAccept && !w_abort;
    assign w_loadOut     = (r_state == DRAIN) && r_rdValid && (!r_outValid || out_tready);
    assign w_lastHs      = r_outValid && out_tready && r_outLast;

    assign w_smpI   = AW'($signed(in_tdata[2*DATA_WIDTH-1:DATA_WIDTH]));
    assign w_smpQ   = AW'($signed(in_tdata[DATA_WIDTH-1:0]));
    assign w_accI   = w_rdData[2*AW-1:AW];
    assign w_accQ   = w_rdData[AW-1:0];
    assign w_wrData = (r_sym == '0) ? {w_smpI, w_smpQ} : {w_accI + w_smpI, w_accQ + w_smpQ};

    assign w_outI = DATA_WIDTH'(roundSat(64'(w_accI), int'(r_kLat), DATA_WIDTH));
    assign w_outQ = DATA_WIDTH'(roundSat(64'(w_accQ), int'(r_kLat), DATA_WIDTH));

    // The read port always targets the index that will be needed next cycle, so
    // accumulation and draining both see their operand one cycle after asking.
    always_comb begin
        w_rdAddr = r_idx;
        if (w_abort) begin
            w_rdAddr = '0;
        end else if (w_inAccept || w_loadOut) begin
            w_rdAddr = r_idx + IW'(1);
        end
    end

    iq_acc_ram #(
        .DEPTH (SYM_LEN),
        .WIDTH (2 * AW),
        .ADDR_W(IW)
    ) u_accRam (
        .clk     (clk),
        .i_wrEn  (w_wrEn),
        .i_wrAddr(r_idx),
        .i_wrData(w_wrData),
        .i_rdAddr(w_rdAddr),
        .o_rdData(w_rdData)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ACCUM;
            r_idx      <= '0;
            r_sym      <= '0;
            r_kLat     <= w_kClip;
            r_inReady  <= 1'b0;
            r_rdValid  <= 1'b0;
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
            r_outData  <= '0;
            r_symDone  <= 1'b0;
            r_abortCnt <= '0;
        end else begin
            r_symDone <= 1'b0;
            case (r_state)
                ACCUM: begin
                    r_inReady <= 1'b1;
                    if (w_inAccept) begin
                        if (w_finalSample) begin
                            r_state   <= DRAIN;
                            r_inReady <= 1'b0;
                            r_idx     <= '0;
                            r_rdValid <= 1'b1;
                        end else if (in_tlast) begin
                            r_idx  <= '0;
                            r_sym  <= '0;
                            r_kLat <= w_kClip;
                            if (r_abortCnt != 16'hFFFF) begin
                                r_abortCnt <= r_abortCnt + 16'd1;
                            end
                        end else begin
                            r_idx <= r_idx + IW'(1);
                            if (r_idx == LAST_IDX) begin
                                r_sym <= r_sym + SW'(1);
                            end
                        end
                    end
                end
                DRAIN: begin
                    // A new sample may enter the output register only when it is empty or being taken.
                    if (w_loadOut) begin
                        r_outData  <= {w_outI, w_outQ};
                        r_outValid <= 1'b1;
                        r_outLast  <= (r_idx == LAST_IDX);
                        if (r_idx == LAST_IDX) begin
                            r_rdValid <= 1'b0;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end else if (out_tready) begin
                        r_outValid <= 1'b0;
                        r_outLast  <= 1'b0;
                    end
                    if (w_lastHs) begin
                        r_symDone <= 1'b1;
                        r_state   <= ACCUM;
                        r_inReady <= 1'b1;
                        r_idx     <= '0;
                        r_sym     <= '0;
                        r_kLat    <= w_kClip;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    assign in_tready   = r_inReady;
    assign out_tdata   = r_outData;
    assign out_tvalid  = r_outValid;
    assign out_tlast   = r_outLast;
    assign sym_done    = r_symDone;
    assign abort_count = r_abortCnt;

endmodule
